// File: rtl/mux_rr_sched_if.sv
// Handshake bundle for the 2:1 mux scheduler: two input lanes, one output lane and the debug counters.
// The slave modport is the scheduler side and the master modport is the producer/consumer side.
interface mux_rr_sched_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic [DATA_W-1:0] data_0;
  logic              valid_0;
  logic              ready_0;
  logic [DATA_W-1:0] data_1;
  logic              valid_1;
  logic              ready_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_out;
  logic              sel_out;
  logic [CNT_W-1:0]  grant_cnt_0;
  logic [CNT_W-1:0]  grant_cnt_1;

  modport slave (
    input  data_0, valid_0, data_1, valid_1, ready_out,
    output ready_0, ready_1, data_out, valid_out, sel_out, grant_cnt_0, grant_cnt_1
  );

  modport master (
    output data_0, valid_0, data_1, valid_1, ready_out,
    input  ready_0, ready_1, data_out, valid_out, sel_out, grant_cnt_0, grant_cnt_1
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Two-lane valid/ready scheduler feeding one registered output lane.
// Mode 0 is work-conserving round-robin with a burst limit; mode 1 strictly alternates lanes.
module mux_rr_sched #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_BURST = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 mode,
  input  logic                 clr_cnt,
  mux_rr_sched_if.slave        bus
);

  localparam int unsigned      BURST_W   = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic              r_last_lane;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_sel_out;
  logic [CNT_W-1:0]  r_cnt_0;
  logic [CNT_W-1:0]  r_cnt_1;

  logic              w_last_lane_nxt;
  logic [BURST_W-1:0] w_burst_cnt_nxt;
  logic [DATA_W-1:0] w_data_out_nxt;
  logic              w_valid_out_nxt;
  logic              w_sel_out_nxt;
  logic [CNT_W-1:0]  w_cnt_0_nxt;
  logic [CNT_W-1:0]  w_cnt_1_nxt;

  logic              w_load;
  logic              w_streak_open;
  logic              w_prio;
  logic              w_gnt_lane;
  logic              w_gnt_vld;
  logic              w_ready_0;
  logic              w_ready_1;
  logic              w_xfer;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_last_lane <= 1'b1;
      r_burst_cnt <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_sel_out   <= 1'b0;
      r_cnt_0     <= '0;
      r_cnt_1     <= '0;
    end else begin
      r_last_lane <= w_last_lane_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_data_out  <= w_data_out_nxt;
      r_valid_out <= w_valid_out_nxt;
      r_sel_out   <= w_sel_out_nxt;
      r_cnt_0     <= w_cnt_0_nxt;
      r_cnt_1     <= w_cnt_1_nxt;
    end
  end

  // Arbitration and input handshake; an empty burst count (after reset) hands priority to lane 0
  always_comb begin
    w_load        = ~r_valid_out | bus.ready_out;
    w_streak_open = (r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX);
    w_prio        = w_streak_open ? r_last_lane : ~r_last_lane;
    w_gnt_lane    = 1'b0;
    w_gnt_vld     = 1'b0;
    if (mode) begin
      w_gnt_lane = ~r_last_lane;
      w_gnt_vld  = r_last_lane ? bus.valid_0 : bus.valid_1;
    end else if (w_prio ? bus.valid_1 : bus.valid_0) begin
      w_gnt_lane = w_prio;
      w_gnt_vld  = 1'b1;
    end else if (w_prio ? bus.valid_0 : bus.valid_1) begin
      w_gnt_lane = ~w_prio;
      w_gnt_vld  = 1'b1;
    end
    w_ready_0 = reset_L & w_load & w_gnt_vld & ~w_gnt_lane;
    w_ready_1 = reset_L & w_load & w_gnt_vld & w_gnt_lane;
    w_xfer    = (w_ready_0 & bus.valid_0) | (w_ready_1 & bus.valid_1);
  end

  // Next-state: output register, burst tracking and saturating grant counters
  always_comb begin
    w_last_lane_nxt = r_last_lane;
    w_burst_cnt_nxt = r_burst_cnt;
    w_data_out_nxt  = r_data_out;
    w_valid_out_nxt = r_valid_out;
    w_sel_out_nxt   = r_sel_out;
    w_cnt_0_nxt     = r_cnt_0;
    w_cnt_1_nxt     = r_cnt_1;

    if (w_xfer) begin
      w_data_out_nxt  = w_gnt_lane ? bus.data_1 : bus.data_0;
      w_sel_out_nxt   = w_gnt_lane;
      w_valid_out_nxt = 1'b1;
      w_last_lane_nxt = w_gnt_lane;
      if (w_gnt_lane == r_last_lane) begin
        w_burst_cnt_nxt = (r_burst_cnt == BURST_MAX) ? r_burst_cnt
                                                     : r_burst_cnt + BURST_W'(1);
      end else begin
        w_burst_cnt_nxt = BURST_W'(1);
      end
      if (!w_gnt_lane && (r_cnt_0 != CNT_MAX)) w_cnt_0_nxt = r_cnt_0 + CNT_W'(1);
      if (w_gnt_lane && (r_cnt_1 != CNT_MAX))  w_cnt_1_nxt = r_cnt_1 + CNT_W'(1);
    end else if (w_load) begin
      w_valid_out_nxt = 1'b0;
    end

    if (clr_cnt) begin
      w_cnt_0_nxt = '0;
      w_cnt_1_nxt = '0;
    end
  end

  assign bus.ready_0     = w_ready_0;
  assign bus.ready_1     = w_ready_1;
  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.sel_out     = r_sel_out;
  assign bus.grant_cnt_0 = r_cnt_0;
  assign bus.grant_cnt_1 = r_cnt_1;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: two instances (MAX_BURST=1/CNT_W=8 and MAX_BURST=3/CNT_W=2),
// a per-cycle reference model per instance, and directed scenarios with literal expectations.
module tb_mux_rr_sched;

  logic clk;
  logic reset_L;
  logic mode;
  logic clr_cnt;

  mux_rr_sched_if #(.DATA_W(4), .CNT_W(8)) ifa ();
  mux_rr_sched_if #(.DATA_W(4), .CNT_W(2)) ifb ();

  mux_rr_sched #(.DATA_W(4), .MAX_BURST(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset_L(reset_L), .mode(mode), .clr_cnt(clr_cnt), .bus(ifa)
  );
  mux_rr_sched #(.DATA_W(4), .MAX_BURST(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset_L(reset_L), .mode(mode), .clr_cnt(clr_cnt), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Per-instance producer FIFOs: index [dut][lane][slot]
  logic [3:0] lbuf [2][2][64];
  int         hd   [2][2];
  int         tl   [2][2];

  // Reference model state per instance
  logic       m_known [2];
  logic       m_vld   [2];
  logic [3:0] m_data  [2];
  logic       m_sel   [2];
  int         m_cnt   [2][2];
  int         run_lane[2];
  int         run_len [2];
  int         mb      [2];
  int         cmax    [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    ifa.valid_0 = hd[0][0] != tl[0][0];
    ifa.data_0  = lbuf[0][0][hd[0][0]];
    ifa.valid_1 = hd[0][1] != tl[0][1];
    ifa.data_1  = lbuf[0][1][hd[0][1]];
    ifb.valid_0 = hd[1][0] != tl[1][0];
    ifb.data_0  = lbuf[1][0][hd[1][0]];
    ifb.valid_1 = hd[1][1] != tl[1][1];
    ifb.data_1  = lbuf[1][1][hd[1][1]];
  endtask

  task automatic push_both(input int g, input logic [3:0] v);
    for (int d = 0; d < 2; d++) begin
      lbuf[d][g][tl[d][g]] = v;
      tl[d][g]++;
    end
    apply();
  endtask

  // One clock: sample accepts mid-cycle, pop them after the edge, re-drive the lanes
  task automatic tick();
    logic a [2][2];
    @(negedge clk);
    a[0][0] = ifa.valid_0 & ifa.ready_0;
    a[0][1] = ifa.valid_1 & ifa.ready_1;
    a[1][0] = ifb.valid_0 & ifb.ready_0;
    a[1][1] = ifb.valid_1 & ifb.ready_1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int g = 0; g < 2; g++)
        if (a[d][g]) hd[d][g]++;
    apply();
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
  endtask

  // Model: decides this cycle's grant from grant history, checks the DUT, then commits the edge
  task automatic model_step(input int d, input logic v0, input logic v1,
                            input logic [3:0] d0, input logic [3:0] d1, input logic ro,
                            input logic r0, input logic r1, input logic vo,
                            input logic [3:0] dout, input logic so,
                            input logic [7:0] c0, input logic [7:0] c1);
    int g;
    int want;
    g = -1;
    if (reset_L === 1'b1 && (!m_vld[d] || ro)) begin
      want = (run_len[d] >= 1 && run_len[d] < mb[d]) ? run_lane[d] : 1 - run_lane[d];
      if (mode) begin
        if ((run_lane[d] == 1) ? v0 : v1) g = 1 - run_lane[d];
      end else if ((want == 0) ? v0 : v1) begin
        g = want;
      end else if ((want == 0) ? v1 : v0) begin
        g = 1 - want;
      end
    end
    chk($sformatf("ready_0[%0d]", d), 8'(r0), 8'(g == 0));
    chk($sformatf("ready_1[%0d]", d), 8'(r1), 8'(g == 1));
    if (m_known[d]) begin
      chk($sformatf("valid_out[%0d]", d), 8'(vo), 8'(m_vld[d]));
      chk($sformatf("data_out[%0d]", d), 8'(dout), 8'(m_data[d]));
      chk($sformatf("sel_out[%0d]", d), 8'(so), 8'(m_sel[d]));
      chk($sformatf("grant_cnt_0[%0d]", d), c0, 8'(m_cnt[d][0]));
      chk($sformatf("grant_cnt_1[%0d]", d), c1, 8'(m_cnt[d][1]));
    end
    if (reset_L !== 1'b1) begin
      m_known[d]  = 1'b1;
      m_vld[d]    = 1'b0;
      m_data[d]   = 4'h0;
      m_sel[d]    = 1'b0;
      m_cnt[d][0] = 0;
      m_cnt[d][1] = 0;
      run_lane[d] = 1;
      run_len[d]  = 0;
    end else begin
      if (g >= 0) begin
        m_data[d] = (g == 1) ? d1 : d0;
        m_sel[d]  = (g == 1);
        m_vld[d]  = 1'b1;
        run_len[d] = (g == run_lane[d]) ? run_len[d] + 1 : 1;
        run_lane[d] = g;
        if (m_cnt[d][g] < cmax[d]) m_cnt[d][g] = m_cnt[d][g] + 1;
      end else if (!m_vld[d] || ro) begin
        m_vld[d] = 1'b0;
      end
      if (clr_cnt) begin
        m_cnt[d][0] = 0;
        m_cnt[d][1] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, ifa.valid_0, ifa.valid_1, ifa.data_0, ifa.data_1, ifa.ready_out,
               ifa.ready_0, ifa.ready_1, ifa.valid_out, ifa.data_out, ifa.sel_out,
               ifa.grant_cnt_0, ifa.grant_cnt_1);
    model_step(1, ifb.valid_0, ifb.valid_1, ifb.data_0, ifb.data_1, ifb.ready_out,
               ifb.ready_0, ifb.ready_1, ifb.valid_out, ifb.data_out, ifb.sel_out,
               8'(ifb.grant_cnt_0), 8'(ifb.grant_cnt_1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       es1 [4];
    logic [3:0] ed1 [4];
    logic       es5 [7];
    logic [3:0] ed5 [7];
    es1 = '{1'b0, 1'b1, 1'b0, 1'b1};
    ed1 = '{4'h1, 4'h8, 4'h2, 4'h9};
    es5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed5 = '{4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'h4};

    checks   = 0;
    failures = 0;
    mb       = '{1, 3};
    cmax     = '{255, 3};
    for (int d = 0; d < 2; d++) begin
      m_known[d] = 1'b0;
      m_vld[d]   = 1'b0;
      m_data[d]  = 4'h0;
      m_sel[d]   = 1'b0;
      run_lane[d] = 1;
      run_len[d]  = 0;
      for (int g = 0; g < 2; g++) begin
        hd[d][g]    = 0;
        tl[d][g]    = 0;
        m_cnt[d][g] = 0;
      end
    end
    reset_L = 1'b0;
    mode    = 1'b0;
    clr_cnt = 1'b0;
    ifa.ready_out = 1'b1;
    ifb.ready_out = 1'b1;
    apply();

    // Both lanes valid through reset, then alternate with MAX_BURST=1
    push_both(0, 4'h1);
    push_both(0, 4'h2);
    push_both(1, 4'h8);
    push_both(1, 4'h9);
    tick();
    tick();
    chk("rst_ready_0", 8'(ifa.ready_0), 8'd0);
    chk("rst_ready_1", 8'(ifa.ready_1), 8'd0);
    chk("rst_valid_out", 8'(ifa.valid_out), 8'd0);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_sel_%0d", i), 8'(ifa.sel_out), 8'(es1[i]));
      chk($sformatf("t1_data_%0d", i), 8'(ifa.data_out), 8'(ed1[i]));
      chk($sformatf("t1_valid_%0d", i), 8'(ifa.valid_out), 8'd1);
    end
    tick();

    // Lane 0 only: back-to-back accepts
    do_reset();
    push_both(0, 4'hA);
    push_both(0, 4'hB);
    push_both(0, 4'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_sel_%0d", i), 8'(ifa.sel_out), 8'd0);
      chk($sformatf("t2_data_%0d", i), 8'(ifa.data_out), 8'(4'hA + i));
    end
    chk("t2_cnt0", ifa.grant_cnt_0, 8'd3);
    chk("t2_cnt1", ifa.grant_cnt_1, 8'd0);
    tick();

    // Strict alternation: lane 1 waits for a lane 0 word after reset
    mode = 1'b1;
    do_reset();
    push_both(1, 4'h6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_ready1_%0d", i), 8'(ifa.ready_1), 8'd0);
      chk($sformatf("t3_valid_%0d", i), 8'(ifa.valid_out), 8'd0);
    end
    push_both(0, 4'h3);
    #1;
    chk("t3_ready0", 8'(ifa.ready_0), 8'd1);
    tick();
    chk("t3_sel_a", 8'(ifa.sel_out), 8'd0);
    chk("t3_data_a", 8'(ifa.data_out), 8'h3);
    chk("t3_ready1_go", 8'(ifa.ready_1), 8'd1);
    tick();
    chk("t3_sel_b", 8'(ifa.sel_out), 8'd1);
    chk("t3_data_b", 8'(ifa.data_out), 8'h6);
    tick();
    mode = 1'b0;

    // Downstream stall holds the output word and blocks both lanes
    do_reset();
    push_both(0, 4'h5);
    tick();
    chk("t4_valid", 8'(ifa.valid_out), 8'd1);
    chk("t4_data", 8'(ifa.data_out), 8'h5);
    ifa.ready_out = 1'b0;
    ifb.ready_out = 1'b0;
    push_both(0, 4'h7);
    push_both(1, 4'hE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_hold_data_%0d", i), 8'(ifa.data_out), 8'h5);
      chk($sformatf("t4_hold_sel_%0d", i), 8'(ifa.sel_out), 8'd0);
      chk($sformatf("t4_ready0_%0d", i), 8'(ifa.ready_0), 8'd0);
      chk($sformatf("t4_ready1_%0d", i), 8'(ifa.ready_1), 8'd0);
    end
    ifa.ready_out = 1'b1;
    ifb.ready_out = 1'b1;
    #1;
    chk("t4_resume_ready1", 8'(ifa.ready_1), 8'd1);
    tick();
    chk("t4_resume_sel", 8'(ifa.sel_out), 8'd1);
    chk("t4_resume_data", 8'(ifa.data_out), 8'hE);
    tick();
    chk("t4_next_data", 8'(ifa.data_out), 8'h7);
    tick();

    // Burst limit of 3 on instance B
    do_reset();
    push_both(0, 4'h1);
    push_both(0, 4'h2);
    push_both(0, 4'h3);
    push_both(0, 4'h4);
    push_both(1, 4'h9);
    push_both(1, 4'hA);
    push_both(1, 4'hB);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t5_sel_%0d", i), 8'(ifb.sel_out), 8'(es5[i]));
      chk($sformatf("t5_data_%0d", i), 8'(ifb.data_out), 8'(ed5[i]));
    end
    tick();

    // Reset mid-stream, clear-vs-grant, counter saturation
    do_reset();
    push_both(0, 4'h1);
    push_both(0, 4'h2);
    push_both(0, 4'h3);
    push_both(1, 4'h5);
    push_both(1, 4'h6);
    push_both(1, 4'h7);
    tick();
    tick();
    reset_L = 1'b0;
    #1;
    chk("t6_rst_ready0", 8'(ifa.ready_0), 8'd0);
    chk("t6_rst_ready1", 8'(ifa.ready_1), 8'd0);
    tick();
    chk("t6_rst_valid", 8'(ifa.valid_out), 8'd0);
    chk("t6_rst_cnt0", ifa.grant_cnt_0, 8'd0);
    chk("t6_rst_cnt1", ifa.grant_cnt_1, 8'd0);
    chk("t6_rst_cnt0_b", 8'(ifb.grant_cnt_0), 8'd0);
    reset_L = 1'b1;
    repeat (8) tick();
    push_both(0, 4'hC);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t6_clr_valid", 8'(ifa.valid_out), 8'd1);
    chk("t6_clr_data", 8'(ifa.data_out), 8'hC);
    chk("t6_clr_cnt0", ifa.grant_cnt_0, 8'd0);
    for (int i = 1; i <= 5; i++) push_both(0, 4'(i));
    repeat (5) tick();
    chk("t6_sat_cnt0_b", 8'(ifb.grant_cnt_0), 8'd3);
    chk("t6_sat_cnt0_a", ifa.grant_cnt_0, 8'd5);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
